// File: rtl/rst_codec.sv
`default_nettype none
// ============================================================================
// Module   : rst_codec
// Brief    : Rotary substitution table codec with key validation, per-beat
//            encrypt/decrypt, configurable rotation and an output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rst_codec #(
    parameter int ROT_STEP   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] key,
    input  logic        key_load,
    output logic        key_busy,
    output logic        key_installed,
    output logic        err_invalid_key,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        err_invalid_in
);
    localparam int              c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = (c_AW)'(1);

    typedef enum logic [1:0] {
        NOKEY  = 2'd0,
        CHECK  = 2'd1,
        READY  = 2'd2,
        KEYERR = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_key [12];
    logic [3:0]      r_idx;
    logic            r_fail;
    logic [7:0]      r_row [6];
    logic [7:0]      r_col [6];
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_err_in;

    logic [7:0]  w_cur;
    logic        w_fail_now;
    logic        w_table_load;
    logic        w_enc_ok;
    logic [5:0]  w_enc_sym;
    logic [2:0]  w_enc_r;
    logic [2:0]  w_enc_c;
    logic [7:0]  w_enc_row;
    logic [7:0]  w_enc_col;
    logic        w_dec_rok;
    logic        w_dec_cok;
    logic [2:0]  w_dec_i;
    logic [2:0]  w_dec_j;
    logic [5:0]  w_dec_sym;
    logic [7:0]  w_dec_char;
    logic        w_beat_ok;
    logic [15:0] w_result;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A)) ||
               ((c >= 8'h30) && (c <= 8'h39));
    endfunction

    assign key_busy        = (r_state == CHECK);
    assign key_installed   = (r_state == READY);
    assign err_invalid_key = (r_state == KEYERR);
    assign in_ready        = key_installed & ~key_busy & (r_count < c_DEPTH);
    assign out_valid       = (r_count != '0);
    assign out_data        = out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign err_invalid_in  = r_err_in;

    assign w_accept     = in_valid & in_ready;
    assign w_push       = w_accept & w_beat_ok;
    assign w_pop        = out_valid & out_ready;
    assign w_table_load = (r_state == CHECK) && (w_state_nxt == READY);

    // Byte under test this CHECK cycle: must be alphanumeric and unique among later bytes
    always_comb begin
        w_cur = 8'h00;
        for (int k = 0; k < 12; k++) begin
            if (r_idx == 4'(k)) w_cur = r_key[k];
        end
        w_fail_now = ~is_alnum(w_cur);
        for (int k = 0; k < 12; k++) begin
            if ((4'(k) > r_idx) && (r_key[k] == w_cur)) w_fail_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= NOKEY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CHECK: begin
                if (r_idx == 4'd11) w_state_nxt = (r_fail | w_fail_now) ? KEYERR : READY;
            end
            default: begin
                if (key_load) w_state_nxt = CHECK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 12; k++) r_key[k] <= 8'h00;
            r_idx  <= 4'd0;
            r_fail <= 1'b0;
        end else if ((r_state != CHECK) && key_load) begin
            for (int k = 0; k < 12; k++) r_key[k] <= key[8*k +: 8];
            r_idx  <= 4'd0;
            r_fail <= 1'b0;
        end else if (r_state == CHECK) begin
            r_idx  <= r_idx + 4'd1;
            r_fail <= r_fail | w_fail_now;
        end
    end

    // Encrypt: fold case, digits follow letters
    always_comb begin
        w_enc_ok  = 1'b1;
        w_enc_sym = 6'd0;
        if ((in_data[7:0] >= 8'h41) && (in_data[7:0] <= 8'h5A))
            w_enc_sym = 6'(in_data[7:0] - 8'h41);
        else if ((in_data[7:0] >= 8'h61) && (in_data[7:0] <= 8'h7A))
            w_enc_sym = 6'(in_data[7:0] - 8'h61);
        else if ((in_data[7:0] >= 8'h30) && (in_data[7:0] <= 8'h39))
            w_enc_sym = 6'(in_data[7:0] - 8'h30 + 8'd26);
        else
            w_enc_ok = 1'b0;
        w_enc_r   = 3'(w_enc_sym / 6'd6);
        w_enc_c   = 3'(w_enc_sym % 6'd6);
        w_enc_row = 8'h00;
        w_enc_col = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (w_enc_r == 3'(i)) w_enc_row = r_row[i];
            if (w_enc_c == 3'(i)) w_enc_col = r_col[i];
        end
    end

    // Decrypt: table entries are unique once validated, so at most one match each
    always_comb begin
        w_dec_rok = 1'b0;
        w_dec_cok = 1'b0;
        w_dec_i   = 3'd0;
        w_dec_j   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (r_row[i] == in_data[15:8]) begin
                w_dec_rok = 1'b1;
                w_dec_i   = 3'(i);
            end
            if (r_col[i] == in_data[7:0]) begin
                w_dec_cok = 1'b1;
                w_dec_j   = 3'(i);
            end
        end
        w_dec_sym  = 6'({3'b000, w_dec_i} * 6'd6 + {3'b000, w_dec_j});
        w_dec_char = (w_dec_sym < 6'd26) ? (8'h41 + {2'b00, w_dec_sym})
                                         : (8'h30 + {2'b00, w_dec_sym} - 8'd26);
    end

    assign w_beat_ok = in_mode ? (w_dec_rok & w_dec_cok & (w_dec_sym < 6'd36)) : w_enc_ok;
    assign w_result  = in_mode ? {8'h00, w_dec_char} : {w_enc_row, w_enc_col};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 6; r++) begin
                r_row[r] <= 8'h00;
                r_col[r] <= 8'h00;
            end
        end else if (w_table_load) begin
            for (int p = 0; p < 3; p++) begin
                r_row[2*p]     <= r_key[11-2*p];
                r_row[2*p + 1] <= r_key[2*p + 1];
                r_col[2*p]     <= r_key[10-2*p];
                r_col[2*p + 1] <= r_key[2*p];
            end
        end else if (w_push) begin
            for (int r = 0; r < 6; r++) begin
                r_row[(r + ROT_STEP) % 6] <= r_row[r];
                r_col[(r + ROT_STEP) % 6] <= r_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err_in <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_err_in <= w_accept & ~w_beat_ok;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rst_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_codec
// Brief    : Scoreboard bench for rst_codec (ROT_STEP=1 and ROT_STEP=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_codec;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [95:0] K_GOOD = "ABCDEFGHIJKL";

    logic        rst = 1'b1;
    logic        key_load = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [95:0] key = '0;
    logic [15:0] in_data = '0;
    logic        use_b = 1'b0;

    logic        a_key_busy, a_key_installed, a_err_invalid_key, a_in_ready, a_out_valid, a_err_invalid_in;
    logic [15:0] a_out_data;
    logic        b_key_busy, b_key_installed, b_err_invalid_key, b_in_ready, b_out_valid, b_err_invalid_in;
    logic [15:0] b_out_data;

    logic        key_busy, key_installed, err_invalid_key, in_ready, out_valid, err_invalid_in;
    logic [15:0] out_data;

    always_comb begin
        key_busy        = use_b ? b_key_busy        : a_key_busy;
        key_installed   = use_b ? b_key_installed   : a_key_installed;
        err_invalid_key = use_b ? b_err_invalid_key : a_err_invalid_key;
        in_ready        = use_b ? b_in_ready        : a_in_ready;
        out_valid       = use_b ? b_out_valid       : a_out_valid;
        err_invalid_in  = use_b ? b_err_invalid_in  : a_err_invalid_in;
        out_data        = use_b ? b_out_data        : a_out_data;
    end

    rst_codec #(.ROT_STEP(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .key(key), .key_load(key_load),
        .key_busy(a_key_busy), .key_installed(a_key_installed), .err_invalid_key(a_err_invalid_key),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .err_invalid_in(a_err_invalid_in)
    );

    rst_codec #(.ROT_STEP(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .key(key), .key_load(key_load),
        .key_busy(b_key_busy), .key_installed(b_key_installed), .err_invalid_key(b_err_invalid_key),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .err_invalid_in(b_err_invalid_in)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [7:0]  m_row [6];
    logic [7:0]  m_col [6];

    // Scoreboard: every pop seen by the DUT is compared with the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h, expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data: got %h, expected %h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_load(input logic [95:0] k);
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) m_row[r] = k[8*(11-r) +: 8];
            else            m_row[r] = k[8*r +: 8];
            if (r % 2 == 0) m_col[r] = k[8*(10-r) +: 8];
            else            m_col[r] = k[8*(r-1) +: 8];
        end
    endtask

    // Reference for the ROT_STEP=1 instance: encode then rotate one position
    task automatic model_enc(input logic [7:0] c, output logic [15:0] res);
        int s;
        logic [7:0] tr [6];
        logic [7:0] tc [6];
        if (c >= 8'h41 && c <= 8'h5A)      s = int'(c) - 65;
        else if (c >= 8'h61 && c <= 8'h7A) s = int'(c) - 97;
        else                               s = int'(c) - 48 + 26;
        res = {m_row[s/6], m_col[s%6]};
        for (int r = 0; r < 6; r++) begin
            tr[(r+1)%6] = m_row[r];
            tc[(r+1)%6] = m_col[r];
        end
        for (int r = 0; r < 6; r++) begin
            m_row[r] = tr[r];
            m_col[r] = tc[r];
        end
    endtask

    task automatic load_key(input logic [95:0] k, input logic ok, input string name);
        int n = 0;
        key = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        checks++;
        if ({key_busy, key_installed, err_invalid_key} !== 3'b100) begin
            errors++;
            $display("FAIL %s_start: busy/inst/err got %b, expected 100", name,
                     {key_busy, key_installed, err_invalid_key});
        end
        while (key_busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, expected 12", name, n);
        end
        checks++;
        if ({key_installed, err_invalid_key} !== {ok, ~ok}) begin
            errors++;
            $display("FAIL %s_result: inst/err got %b, expected %b", name,
                     {key_installed, err_invalid_key}, {ok, ~ok});
        end
    endtask

    task automatic send(input logic mode, input logic [15:0] d, input logic [15:0] exp, input bit push_exp);
        int n = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got %b, expected 1 for data %h", in_ready, d);
        end else begin
            @(posedge clk); #1;
            if (push_exp) exp_q.push_back(exp);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending got %0d, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_busy, key_installed, err_invalid_key, in_ready, out_valid, err_invalid_in} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {key_busy, key_installed, err_invalid_key, in_ready, out_valid, err_invalid_in});
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_data: got %h, expected 0000", out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt();
        load_key(K_GOOD, 1'b1, "enc_key");
        send(1'b0, {8'h00, "H"}, "KL", 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL enc_latency: out_valid got %b, expected 1", out_valid);
        end
        send(1'b0, {8'h00, "e"}, "GJ", 1'b1);
        send(1'b0, {8'h00, "l"}, "GJ", 1'b1);
        send(1'b0, {8'h00, "l"}, "ED", 1'b1);
        send(1'b0, {8'h00, "o"}, "EF", 1'b1);
        wait_drain("enc");
    endtask

    task automatic test_decrypt();
        load_key(K_GOOD, 1'b1, "dec_key");
        send(1'b1, "KL", {8'h00, "H"}, 1'b1);
        send(1'b1, "GJ", {8'h00, "E"}, 1'b1);
        send(1'b1, "ZZ", 16'h0000, 1'b0);
        checks++;
        if (err_invalid_in !== 1'b1) begin
            errors++;
            $display("FAIL dec_err_pulse: got %b, expected 1", err_invalid_in);
        end
        @(posedge clk); #1;
        checks++;
        if (err_invalid_in !== 1'b0) begin
            errors++;
            $display("FAIL dec_err_one_cycle: got %b, expected 0", err_invalid_in);
        end
        send(1'b1, "GL", {8'h00, "J"}, 1'b1);
        wait_drain("dec");
    endtask

    task automatic test_key_errors();
        int seen_ready = 0;
        load_key("ABC?*-.HIJKL", 1'b0, "key_badchar");
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL keyerr_in_ready: got %b, expected 0", in_ready);
        end
        load_key("ABCDEFGHDDKL", 1'b0, "key_dup");
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = {8'h00, "A"};
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0) seen_ready++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (seen_ready != 0) begin
            errors++;
            $display("FAIL keyerr_blocks_input: ready cycles got %0d, expected 0", seen_ready);
        end
        load_key(K_GOOD, 1'b1, "key_recover");
        wait_drain("keyerr");
    endtask

    task automatic test_backpressure();
        logic [7:0]  chars [6];
        logic [15:0] e;
        int idx = 0;
        chars = '{"H", "E", "L", "L", "O", "9"};
        load_key(K_GOOD, 1'b1, "bp_key");
        model_load(K_GOOD);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = {8'h00, chars[0]};
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && idx < 6) begin
                @(posedge clk); #1;
                model_enc(chars[idx], e);
                exp_q.push_back(e);
                idx++;
                if (idx < 6) in_data = {8'h00, chars[idx]};
            end
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL bp_accepted: got %0d, expected 4", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && idx < 6; cyc++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                model_enc(chars[idx], e);
                exp_q.push_back(e);
                idx++;
                if (idx < 6) in_data = {8'h00, chars[idx]};
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL bp_resume: got %0d, expected 6", idx);
        end
        wait_drain("bp");
    endtask

    task automatic test_invalid_encrypt();
        load_key(K_GOOD, 1'b1, "inv_key");
        send(1'b0, {8'h00, "a"}, "AB", 1'b1);
        send(1'b0, {8'h00, "-"}, 16'h0000, 1'b0);
        checks++;
        if (err_invalid_in !== 1'b1) begin
            errors++;
            $display("FAIL inv_err_pulse: got %b, expected 1", err_invalid_in);
        end
        send(1'b0, {8'h00, "b"}, "GB", 1'b1);
        wait_drain("inv");
    endtask

    task automatic test_rot2_reset();
        int seen_ready = 0;
        use_b = 1'b1;
        load_key(K_GOOD, 1'b1, "rot2_key");
        send(1'b0, {8'h00, "H"}, "KL", 1'b1);
        send(1'b0, {8'h00, "e"}, "ED", 1'b1);
        send(1'b0, {8'h00, "l"}, "IL", 1'b1);
        wait_drain("rot2");
        out_ready = 1'b0;
        send(1'b0, {8'h00, "l"}, 16'h0000, 1'b0);
        send(1'b0, {8'h00, "o"}, 16'h0000, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rot2_prefill: out_valid got %b, expected 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({key_busy, key_installed, err_invalid_key, in_ready, out_valid, err_invalid_in, out_data} !== 22'b0) begin
            errors++;
            $display("FAIL midrst_outputs: flags %b data %h, expected all 0",
                     {key_busy, key_installed, err_invalid_key, in_ready, out_valid, err_invalid_in}, out_data);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8'h00, "H"};
        repeat (4) begin
            @(negedge clk);
            if (in_ready !== 1'b0) seen_ready++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (seen_ready != 0) begin
            errors++;
            $display("FAIL midrst_needs_key: ready cycles got %0d, expected 0", seen_ready);
        end
        load_key(K_GOOD, 1'b1, "rot2_reload");
        send(1'b0, {8'h00, "H"}, "KL", 1'b1);
        wait_drain("rot2_after_rst");
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_key_errors();
        test_backpressure();
        test_invalid_encrypt();
        test_rot2_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
